axi_wr_subordinate: RTL

AXI_WR_SUBORDINATE -- requirements
Module: axi_wr_subordinate

---
 rtl/axi_wr_subordinate_if.sv | 40 ++++
 rtl/axi_wr_subordinate.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/axi_wr_subordinate_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the subordinate and its bench.
// The master modport drives requests and data; the slave modport drives ready and response.
interface axi_wr_subordinate_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ID_W-1:0]       aw_id;
    logic [ADDR_W-1:0]     aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic                  w_last;

    logic                  b_valid;
    logic                  b_ready;
    logic [ID_W-1:0]       b_id;
    logic [1:0]            b_resp;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output w_valid, w_data, w_strb, w_last,
        output b_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp
    );
endinterface

// File: rtl/axi_wr_subordinate.sv
// AXI4 write subordinate backed by a DEPTH-word memory, one transaction in flight at a time.
// Define AXI_WR_SUBORDINATE_WRAP_EN to support WRAP bursts; otherwise they complete with SLVERR.
module axi_wr_subordinate #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_wr_subordinate_if.slave        axi,
    input  logic [$clog2(DEPTH)-1:0]   dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * STRB_W);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        beat_q, beat_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              awHs, wHs, bHs;
    logic              awErr, inRange, lastBeat, beatErr, memWe;
    logic [ADDR_W-1:0] offset, stepBytes, incrAddr, nextAddr;
    logic [IDX_W-1:0]  memIdx;

    // Readies are held low while reset is asserted so nothing is accepted mid-reset.
    assign axi.aw_ready = (state_q == IDLE) && !rst;
    assign axi.w_ready  = (state_q == DATA) && !rst;
    assign axi.b_valid  = (state_q == RESP) && !rst;
    assign axi.b_id     = axi.b_valid ? id_q : '0;
    assign axi.b_resp   = (axi.b_valid && err_q) ? 2'b10 : 2'b00;

    assign awHs = axi.aw_valid && axi.aw_ready;
    assign wHs  = axi.w_valid && axi.w_ready;
    assign bHs  = axi.b_valid && axi.b_ready;

    assign offset    = addr_q - BASE_ADDR;
    assign inRange   = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign memIdx    = IDX_W'(offset >> LSB);
    assign lastBeat  = (beat_q == len_q);
    assign beatErr   = err_q || !inRange || (axi.w_last && !lastBeat);
    assign memWe     = wHs && !beatErr;
    assign stepBytes = ADDR_W'(1) << size_q;
    assign incrAddr  = addr_q + stepBytes;

`ifdef AXI_WR_SUBORDINATE_WRAP_EN
    logic [ADDR_W-1:0] wrapMask;

    // Window is (len+1)<<size bytes; low bits advance, high bits stay on the aligned base.
    assign wrapMask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
`endif

    always_comb begin
        awErr = (axi.aw_burst == 2'b11) || (int'(axi.aw_size) > LSB);
`ifdef AXI_WR_SUBORDINATE_WRAP_EN
        if (axi.aw_burst == 2'b10 && !(axi.aw_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            awErr = 1'b1;
`else
        if (axi.aw_burst == 2'b10)
            awErr = 1'b1;
`endif
    end

    always_comb begin
        nextAddr = addr_q;
        case (burst_q)
            2'b01:   nextAddr = incrAddr;
`ifdef AXI_WR_SUBORDINATE_WRAP_EN
            2'b10:   nextAddr = (addr_q & ~wrapMask) | (incrAddr & wrapMask);
`endif
            default: nextAddr = addr_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (awHs) begin
                    id_d    = axi.aw_id;
                    addr_d  = axi.aw_addr;
                    len_d   = axi.aw_len;
                    size_d  = axi.aw_size;
                    burst_d = axi.aw_burst;
                    beat_d  = '0;
                    err_d   = awErr;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wHs) begin
                    beat_d = beat_q + 8'd1;
                    err_d  = beatErr;
                    addr_d = nextAddr;
                    if (axi.w_last || lastBeat)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (bHs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside reset so contents survive an abandoned transaction.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi.w_strb[i])
                    mem[memIdx][i*8 +: 8] <= axi.w_data[i*8 +: 8];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];
endmodule
